// File: rtl/rx_node.sv
// rtl/rx_node.sv - dual-rail four-phase receiver that decodes and routes a payload to one of two children
//
// Purpose: synchronizes a dual-rail four-phase codeword from an upstream TX
// node, decodes it into an N-bit binary payload plus a one-bit route, holds it
// in a single output register, and acknowledges upstream with in_a.
//
// Ports:
//   clk, rst              - clock and asynchronous active-high reset
//   in_d[2*(N+1)-1:0]     - dual-rail codeword (N data pairs + route pair at top)
//   in_a                  - registered four-phase acknowledge to upstream
//   out0_data/valid/ready - payload handshake towards child 0
//   out1_data/valid/ready - payload handshake towards child 1
//   err                   - sticky flag, set when any pair reads 11
module rx_node #(
  parameter int N = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*(N+1)-1:0] in_d,
  output logic               in_a,
  output logic [N-1:0]       out0_data,
  output logic               out0_valid,
  input  logic               out0_ready,
  output logic [N-1:0]       out1_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic               err
);

  localparam int W = 2 * (N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    ERR  = 2'd2
  } state_t;

  logic [W-1:0] s1_q, s2_q;
  state_t       state_q, state_d;
  logic         in_a_q, in_a_d;
  logic         full_q, full_d;
  logic         route_q, route_d;
  logic [N-1:0] payload_q, payload_d;
  logic         err_q, err_d;

  logic         complete, illegal, spacer, xfer;
  logic [N-1:0] cw_payload;
  logic [1:0]   pair;

  // Codeword classification, taken from the second synchronizer stage only.
  always_comb begin
    complete   = 1'b1;
    illegal    = 1'b0;
    pair       = 2'b00;
    cw_payload = '0;
    for (int i = 0; i <= N; i++) begin
      pair = s2_q[2*i +: 2];
      if (pair == 2'b00) complete = 1'b0;
      if (pair == 2'b11) illegal  = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      // 10 means bit = 1, 01 means bit = 0; the upper rail carries the value.
      cw_payload[i] = s2_q[2*i+1];
    end
    complete = complete & ~illegal;
    spacer   = (s2_q == '0);
  end

  // A transfer drains the register at this edge; route 1 selects child 1.
  assign xfer = full_q & (route_q ? out1_ready : out0_ready);

  always_comb begin
    state_d   = state_q;
    in_a_d    = in_a_q;
    full_d    = full_q;
    route_d   = route_q;
    payload_d = payload_q;
    err_d     = err_q;

    if (xfer) full_d = 1'b0;

    if (illegal) begin
      state_d = ERR;
      err_d   = 1'b1;
      in_a_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Capture may share the edge with a transfer of the old payload.
          if (complete && (!full_q || xfer)) begin
            payload_d = cw_payload;
            route_d   = s2_q[2*N+1];
            full_d    = 1'b1;
            in_a_d    = 1'b1;
            state_d   = ACK;
          end
        end
        ACK: begin
          if (spacer) begin
            in_a_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          // ERR holds until reset; any remaining payload still drains above.
          in_a_d  = 1'b0;
          state_d = ERR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      state_q   <= IDLE;
      in_a_q    <= 1'b0;
      full_q    <= 1'b0;
      route_q   <= 1'b0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      s1_q      <= in_d;
      s2_q      <= s1_q;
      state_q   <= state_d;
      in_a_q    <= in_a_d;
      full_q    <= full_d;
      route_q   <= route_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  assign in_a       = in_a_q;
  assign err        = err_q;
  assign out0_data  = payload_q;
  assign out1_data  = payload_q;
  assign out0_valid = full_q & ~route_q;
  assign out1_valid = full_q & route_q;

endmodule

// File: tb/tb_rx_node.sv
// tb/tb_rx_node.sv - directed self-checking bench for rx_node with N=4
module tb_rx_node;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [9:0]   in_d = '0;
  logic         in_a;
  logic [N-1:0] out0_data, out1_data;
  logic         out0_valid, out1_valid;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  logic       mon_en = 1'b0;
  logic [4:0] got_q[$];

  rx_node #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_d       (in_d),
    .in_a       (in_a),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a dual-rail codeword: route 0 -> 01, route 1 -> 10; bit 1 -> 10, bit 0 -> 01.
  function automatic logic [9:0] cw(input logic r, input logic [3:0] d);
    logic [9:0] w;
    w[9:8] = r ? 2'b10 : 2'b01;
    for (int i = 0; i < 4; i++) w[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
    return w;
  endfunction

  task automatic wait_ack(input logic lvl, input string tag);
    int n;
    n = 0;
    while (in_a !== lvl && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(in_a), 32'(lvl));
  endtask

  // Records every transfer the cycle before its edge; ready is held during use.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_exclusive", 32'(out0_valid & out1_valid), 32'd0);
      if (out0_valid && out0_ready) got_q.push_back({1'b0, out0_data});
      if (out1_valid && out1_ready) got_q.push_back({1'b1, out1_data});
    end
  end

  initial begin
    logic [9:0] tgt;
    logic [4:0] exp_e;

    // Reset state
    #3 rst = 1'b1;
    #1;
    chk("rst_in_a", 32'(in_a), 32'd0);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", 32'(out0_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Basic route-0 transfer with latency check
    out0_ready = 1'b1;
    in_d = 10'b01_10_01_10_01;
    tick();
    tick();
    chk("t1_no_early_ack", 32'(in_a), 32'd0);
    chk("t1_no_early_v0", 32'(out0_valid), 32'd0);
    tick();
    chk("t1_ack", 32'(in_a), 32'd1);
    chk("t1_v0", 32'(out0_valid), 32'd1);
    chk("t1_d0", 32'(out0_data), 32'hA);
    chk("t1_v1", 32'(out1_valid), 32'd0);
    tick();
    chk("t1_v0_pulse", 32'(out0_valid), 32'd0);
    chk("t1_ack_held", 32'(in_a), 32'd1);
    in_d = '0;
    tick();
    tick();
    chk("t1_ack_before_spacer", 32'(in_a), 32'd1);
    tick();
    chk("t1_ack_fall", 32'(in_a), 32'd0);

    // Back-pressure on child 1, then a second codeword waits for the drain
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_d = cw(1'b1, 4'h5);
    tick(); tick(); tick();
    chk("t2_ack", 32'(in_a), 32'd1);
    chk("t2_v1", 32'(out1_valid), 32'd1);
    chk("t2_d1", 32'(out1_data), 32'h5);
    in_d = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_hs_done", 32'(in_a), 32'd0);
    chk("t2_v1_held", 32'(out1_valid), 32'd1);
    chk("t2_d1_held", 32'(out1_data), 32'h5);
    in_d = cw(1'b0, 4'h3);
    for (int i = 0; i < 6; i++) tick();
    chk("t2_wait_no_ack", 32'(in_a), 32'd0);
    chk("t2_wait_v1", 32'(out1_valid), 32'd1);
    chk("t2_wait_d1", 32'(out1_data), 32'h5);
    chk("t2_wait_v0", 32'(out0_valid), 32'd0);
    out1_ready = 1'b1;
    tick();
    chk("t2_same_edge_ack", 32'(in_a), 32'd1);
    chk("t2_same_edge_v1", 32'(out1_valid), 32'd0);
    chk("t2_same_edge_v0", 32'(out0_valid), 32'd1);
    chk("t2_same_edge_d0", 32'(out0_data), 32'h3);
    out1_ready = 1'b0;
    out0_ready = 1'b1;
    tick();
    chk("t2_drain_v0", 32'(out0_valid), 32'd0);
    in_d = '0;
    wait_ack(1'b0, "t2_spacer_ack");

    // Skewed arrival, one pair per cycle
    tgt = cw(1'b0, 4'h6);
    for (int p = 0; p < 5; p++) begin
      in_d[2*p +: 2] = tgt[2*p +: 2];
      tick();
      chk("t3_skew_no_ack", 32'(in_a), 32'd0);
      chk("t3_skew_no_v0", 32'(out0_valid), 32'd0);
    end
    tick();
    chk("t3_skew_no_ack_s2", 32'(in_a), 32'd0);
    tick();
    chk("t3_ack", 32'(in_a), 32'd1);
    chk("t3_v0", 32'(out0_valid), 32'd1);
    chk("t3_d0", 32'(out0_data), 32'h6);
    tick();
    chk("t3_drain", 32'(out0_valid), 32'd0);
    in_d = '0;
    wait_ack(1'b0, "t3_spacer_ack");

    // Illegal pair 2 -> sticky error, no captures, then reset recovers
    out0_ready = 1'b0;
    in_d = cw(1'b0, 4'h0) | 10'b00_00_11_00_00;
    tick(); tick(); tick();
    chk("t4_err", 32'(err), 32'd1);
    in_d = cw(1'b0, 4'h9);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_err_sticky", 32'(err), 32'd1);
      chk("t4_in_a_low", 32'(in_a), 32'd0);
    end
    chk("t4_no_capture", 32'(out0_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t4_resume_ack", 32'(in_a), 32'd1);
    chk("t4_resume_v0", 32'(out0_valid), 32'd1);
    chk("t4_resume_d0", 32'(out0_data), 32'h9);
    out0_ready = 1'b1;
    in_d = '0;
    wait_ack(1'b0, "t4_spacer_ack");
    tick();
    chk("t4_drained", 32'(out0_valid), 32'd0);

    // Reset in ACK with a full register; exactly one re-capture afterwards
    out0_ready = 1'b0;
    in_d = cw(1'b0, 4'hC);
    tick(); tick(); tick();
    chk("t5_ack", 32'(in_a), 32'd1);
    chk("t5_full", 32'(out0_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_in_a", 32'(in_a), 32'd0);
    chk("t5_rst_v0", 32'(out0_valid), 32'd0);
    chk("t5_rst_v1", 32'(out1_valid), 32'd0);
    chk("t5_rst_d0", 32'(out0_data), 32'd0);
    chk("t5_rst_d1", 32'(out1_data), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t5_recap_ack", 32'(in_a), 32'd1);
    chk("t5_recap_v0", 32'(out0_valid), 32'd1);
    chk("t5_recap_d0", 32'(out0_data), 32'hC);
    out0_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_single_capture", 32'(out0_valid), 32'd0);
      chk("t5_ack_held", 32'(in_a), 32'd1);
    end
    in_d = '0;
    wait_ack(1'b0, "t5_spacer_ack");

    // Back-to-back: 8 codewords, alternating route, both readies high
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    got_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_d = cw(i[0], 4'(3 + 5 * i));
      wait_ack(1'b1, "t6_ack_rise");
      in_d = '0;
      wait_ack(1'b0, "t6_ack_fall");
    end
    tick(); tick();
    mon_en = 1'b0;
    chk("t6_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_e = {i[0], 4'(3 + 5 * i)};
      if (i < got_q.size()) chk("t6_entry", 32'(got_q[i]), 32'(exp_e));
      else chk("t6_entry_missing", 32'd0, 32'(exp_e) | 32'h100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
